// File: rtl/datamover_ctrl_slave_if.sv
// Peripheral-bus port bundle between the host-side initiator and the datamover control slave.
// The host drives the request fields; the slave returns the grant and a registered response.
interface datamover_ctrl_slave_if #(
    parameter int ID = 5
) ();
    logic          req;
    logic          gnt;
    logic [31:0]   add;
    logic          wen;
    logic [3:0]    be;
    logic [31:0]   data;
    logic [ID-1:0] id;
    logic [31:0]   r_data;
    logic          r_valid;
    logic [ID-1:0] r_id;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_data, r_valid, r_id
    );

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_data, r_valid, r_id
    );
endinterface

// File: rtl/datamover_ctrl_slave.sv
// HWPE-style control slave for the datamover: acquire/commit/status/soft-clear decode,
// job register file, engine start/clear pulses and end-of-job events to the cores.
module datamover_ctrl_slave #(
    parameter int ID      = 5,
    parameter int N_CORES = 1,
    parameter int N_REGS  = 13
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    datamover_ctrl_slave_if.slave  periph,
    output logic [N_REGS*32-1:0]   cfg_o,
    output logic                   start_o,
    output logic                   clear_o,
    input  logic                   done_i,
    output logic                   busy_o,
    output logic [N_CORES-1:0]     evt_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRED,
        RUNNING
    } state_e;

    localparam logic [7:0] ADDR_COMMIT  = 8'h00;
    localparam logic [7:0] ADDR_ACQUIRE = 8'h04;
    localparam logic [7:0] ADDR_STATUS  = 8'h0C;
    localparam logic [7:0] ADDR_CLEAR   = 8'h14;

    state_e        state_q, state_d;
    logic [3:0]    job_id_q;
    logic [31:0]   regs_q [N_REGS];

    logic          start_d, evt_d, clear_d;
    logic [31:0]   rdata_d;

    logic          start_q, clear_q, evt_q;
    logic          r_valid_q;
    logic [31:0]   r_data_q;
    logic [ID-1:0] r_id_q;

    // Address decode: only the low byte is significant.
    logic [7:0] addr;
    logic [3:0] job_idx;
    logic       job_hit;
    logic       acquire_rd, status_rd, commit_wr, clear_wr, job_rd, job_wr;
    logic       unused_addr;

    assign addr        = periph.add[7:0];
    assign unused_addr = ^periph.add[31:8];
    assign job_idx     = addr[5:2];
    assign job_hit     = (addr[7:6] == 2'b01) && (addr[1:0] == 2'b00) && (int'(job_idx) < N_REGS);

    assign acquire_rd = periph.req &&  periph.wen && (addr == ADDR_ACQUIRE);
    assign status_rd  = periph.req &&  periph.wen && (addr == ADDR_STATUS);
    assign commit_wr  = periph.req && !periph.wen && (addr == ADDR_COMMIT);
    assign clear_wr   = periph.req && !periph.wen && (addr == ADDR_CLEAR);
    assign job_rd     = periph.req &&  periph.wen && job_hit;
    // Job registers are frozen outside ACQUIRED so cfg_o cannot change under a running job.
    assign job_wr     = periph.req && !periph.wen && job_hit && (state_q == ACQUIRED);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        evt_d   = 1'b0;
        clear_d = 1'b0;
        rdata_d = '0;

        case (state_q)
            IDLE:     if (acquire_rd) state_d = ACQUIRED;
            ACQUIRED: if (commit_wr) begin
                          state_d = RUNNING;
                          start_d = 1'b1;
                      end
            RUNNING:  if (done_i) begin
                          state_d = IDLE;
                          evt_d   = 1'b1;
                      end
            default:  state_d = IDLE;
        endcase

        // Soft clear overrides any concurrent commit or end-of-job.
        if (clear_wr) begin
            state_d = IDLE;
            start_d = 1'b0;
            evt_d   = 1'b0;
            clear_d = 1'b1;
        end

        if (acquire_rd) begin
            rdata_d = (state_q == IDLE) ? {28'b0, job_id_q} : 32'hFFFF_FFFF;
        end else if (status_rd) begin
            rdata_d = {31'b0, (state_q == RUNNING)};
        end else if (job_rd) begin
            rdata_d = regs_q[job_idx];
        end
    end

    // NOTE: sequential state is assigned with <= so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the job register file is reset because its contents are visible on cfg_o and
    // soft clear must zero it anyway; this is a flop array, not a RAM macro.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_d) begin
            for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
            job_id_q <= '0;
        end else begin
            if (job_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (periph.be[b]) regs_q[job_idx][8*b +: 8] <= periph.data[8*b +: 8];
                end
            end
            if (evt_d) job_id_q <= job_id_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            start_q   <= 1'b0;
            clear_q   <= 1'b0;
            evt_q     <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_id_q    <= '0;
        end else begin
            start_q   <= start_d;
            clear_q   <= clear_d;
            evt_q     <= evt_d;
            r_valid_q <= periph.req;
            r_data_q  <= rdata_d;
            if (periph.req) r_id_q <= periph.id;
        end
    end

    assign periph.gnt     = periph.req;
    assign periph.r_valid = r_valid_q;
    assign periph.r_data  = r_data_q;
    assign periph.r_id    = r_id_q;

    for (genvar g = 0; g < N_REGS; g++) begin : g_cfg
        assign cfg_o[g*32 +: 32] = regs_q[g];
    end

    assign start_o = start_q;
    assign clear_o = clear_q;
    assign busy_o  = (state_q == RUNNING);
    assign evt_o   = {N_CORES{evt_q}};

endmodule

// File: tb/tb_datamover_ctrl_slave.sv
// Directed bench for datamover_ctrl_slave: inputs change and outputs are sampled on the
// falling clock edge; expected values are written by hand next to each step.
module tb_datamover_ctrl_slave;

    localparam int ID      = 5;
    localparam int N_CORES = 1;
    localparam int N_REGS  = 13;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  done;
    logic [N_REGS*32-1:0]  cfg;
    logic                  start, clear, busy;
    logic [N_CORES-1:0]    evt;

    int checks = 0;
    int passed = 0;

    datamover_ctrl_slave_if #(.ID(ID)) bus ();

    datamover_ctrl_slave #(.ID(ID), .N_CORES(N_CORES), .N_REGS(N_REGS)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .periph  (bus),
        .cfg_o   (cfg),
        .start_o (start),
        .clear_o (clear),
        .done_i  (done),
        .busy_o  (busy),
        .evt_o   (evt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic w, input logic [7:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic [ID-1:0] i);
        bus.req  = 1'b1;
        bus.wen  = w;
        bus.add  = {24'h0, a};
        bus.be   = b;
        bus.data = d;
        bus.id   = i;
    endtask

    task automatic idle();
        bus.req  = 1'b0;
        bus.wen  = 1'b1;
        bus.add  = '0;
        bus.be   = '0;
        bus.data = '0;
        bus.id   = '0;
    endtask

    // One access, then idle; returns at the falling edge where the response is visible.
    task automatic acc(input logic w, input logic [7:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [ID-1:0] i);
        @(negedge clk);
        drive(w, a, b, d, i);
        @(negedge clk);
        idle();
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] exp_data, input logic [ID-1:0] exp_id);
        check({tag, "_valid"}, 32'(bus.r_valid), 32'd1);
        check({tag, "_data"},  bus.r_data,       exp_data);
        check({tag, "_id"},    32'(bus.r_id),    32'(exp_id));
    endtask

    initial begin
        idle();
        done = 1'b0;
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_r_valid", 32'(bus.r_valid), 32'd0);
        check("rst_r_data",  bus.r_data,       32'd0);
        check("rst_start",   32'(start),       32'd0);
        check("rst_clear",   32'(clear),       32'd0);
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_evt",     32'(evt),         32'd0);
        check("rst_cfg",     32'(|cfg),        32'd0);

        // First acquire in IDLE returns job_id 0; grant follows request combinationally.
        @(negedge clk);
        drive(1'b1, 8'h04, 4'h0, 32'h0, 5'd3);
        #1 check("gnt", 32'(bus.gnt), 32'd1);
        @(negedge clk);
        idle();
        check_rsp("acq_idle", 32'h0, 5'd3);
        check("acq_busy", 32'(busy), 32'd0);

        acc(1'b1, 8'h04, 4'h0, 32'h0, 5'd4);
        check_rsp("acq_again", 32'hFFFF_FFFF, 5'd4);

        // Job register writes in ACQUIRED, including a partial-byte write.
        acc(1'b0, 8'h48, 4'hF, 32'hAAAA_AAAA, 5'd5);
        check_rsp("wr_rsp", 32'h0, 5'd5);
        acc(1'b0, 8'h40, 4'hF, 32'h0000_0100, 5'd6);
        acc(1'b0, 8'h48, 4'b0011, 32'h0000_0010, 5'd7);
        check("cfg_reg0", cfg[31:0],  32'h0000_0100);
        check("cfg_reg2", cfg[95:64], 32'hAAAA_0010);
        acc(1'b1, 8'h48, 4'h0, 32'h0, 5'd8);
        check_rsp("rd_reg2", 32'hAAAA_0010, 5'd8);
        acc(1'b1, 8'h0C, 4'h0, 32'h0, 5'd10);
        check_rsp("status_acq", 32'h0, 5'd10);

        // Commit, then STATUS read in the start cycle.
        @(negedge clk);
        drive(1'b0, 8'h00, 4'hF, 32'hDEAD_BEEF, 5'd11);
        @(negedge clk);
        check("commit_start", 32'(start), 32'd1);
        check("commit_busy",  32'(busy),  32'd1);
        drive(1'b1, 8'h0C, 4'h0, 32'h0, 5'd12);
        @(negedge clk);
        idle();
        check("start_one_cycle", 32'(start), 32'd0);
        check_rsp("status_run", 32'h1, 5'd12);

        acc(1'b0, 8'h40, 4'hF, 32'h0000_0005, 5'd13);
        check("cfg_frozen", cfg[31:0], 32'h0000_0100);
        acc(1'b1, 8'h04, 4'h0, 32'h0, 5'd14);
        check_rsp("acq_run", 32'hFFFF_FFFF, 5'd14);

        // End of job.
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("done_evt",  32'(evt),  32'd1);
        check("done_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("evt_one_cycle", 32'(evt), 32'd0);
        acc(1'b1, 8'h0C, 4'h0, 32'h0, 5'd16);
        check_rsp("status_idle", 32'h0, 5'd16);
        acc(1'b1, 8'h04, 4'h0, 32'h0, 5'd15);
        check_rsp("acq_job1", 32'h1, 5'd15);

        // Soft clear concurrent with done while RUNNING.
        acc(1'b0, 8'h00, 4'hF, 32'h0, 5'd16);
        check("commit2_start", 32'(start), 32'd1);
        @(negedge clk);
        drive(1'b0, 8'h14, 4'hF, 32'h0, 5'd17);
        done = 1'b1;
        @(negedge clk);
        idle();
        done = 1'b0;
        check("clr_pulse", 32'(clear), 32'd1);
        check("clr_no_evt", 32'(evt),  32'd0);
        check("clr_busy",  32'(busy),  32'd0);
        check("clr_cfg",   32'(|cfg),  32'd0);
        check_rsp("clr_rsp", 32'h0, 5'd17);
        @(negedge clk);
        check("clr_one_cycle", 32'(clear), 32'd0);

        // Commit in IDLE is ignored.
        acc(1'b0, 8'h00, 4'hF, 32'h0, 5'd18);
        check("commit_idle_start", 32'(start), 32'd0);
        check("commit_idle_busy",  32'(busy),  32'd0);
        acc(1'b1, 8'h04, 4'h0, 32'h0, 5'd19);
        check_rsp("acq_after_clr", 32'h0, 5'd19);
        acc(1'b0, 8'h44, 4'hF, 32'h1234_5678, 5'd20);

        // Back-to-back reads, one per cycle.
        @(negedge clk);
        drive(1'b1, 8'h0C, 4'h0, 32'h0, 5'd1);
        @(negedge clk);
        check_rsp("b2b_1", 32'h0, 5'd1);
        drive(1'b1, 8'h44, 4'h0, 32'h0, 5'd2);
        @(negedge clk);
        check_rsp("b2b_2", 32'h1234_5678, 5'd2);
        drive(1'b1, 8'h99, 4'h0, 32'h0, 5'd3);
        @(negedge clk);
        idle();
        check_rsp("b2b_3", 32'h0, 5'd3);
        @(negedge clk);
        check("b2b_end", 32'(bus.r_valid), 32'd0);

        // done and ACQUIRE in the same cycle: the read sees RUNNING.
        acc(1'b0, 8'h00, 4'hF, 32'h0, 5'd21);
        check("commit3_start", 32'(start), 32'd1);
        @(negedge clk);
        drive(1'b1, 8'h04, 4'h0, 32'h0, 5'd22);
        done = 1'b1;
        @(negedge clk);
        idle();
        done = 1'b0;
        check_rsp("acq_done_same", 32'hFFFF_FFFF, 5'd22);
        check("acq_done_evt", 32'(evt), 32'd1);
        acc(1'b1, 8'h04, 4'h0, 32'h0, 5'd23);
        check_rsp("acq_job1_again", 32'h1, 5'd23);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/datamover_ctrl_slave.md
Name: datamover_ctrl_slave

Overview:
- Peripheral-bus responder and job controller for the datamover. It is the target end of the periph_req/gnt/add/wen/be/data/id/r_data/r_valid/r_id interface that the host side initiates.
- Decodes HWPE control accesses: acquire, commit-and-trigger, status and soft clear.
- Holds the 13 job registers and drives start/clear to the streaming engine.
- Returns end-of-job events to the cores.

Parameters:
ID, 5, width of the periph transaction id.
N_CORES, 1, number of event lines in evt_o.
N_REGS, 13, number of job registers.

Ports:
clk_i  in  1  clock; all logic on the rising edge.
rst_i  in  1  reset, synchronous, active-high.
periph_req_i  in  1  request.
periph_gnt_o  out  1  grant.
periph_add_i  in  32  byte address; only bits [7:0] are decoded.
periph_wen_i  in  1  1 = read, 0 = write.
periph_be_i  in  4  byte enables for writes.
periph_data_i  in  32  write data.
periph_id_i  in  ID  transaction id.
periph_r_data_o  out  32  read data.
periph_r_valid_o  out  1  response valid.
periph_r_id_o  out  ID  response id.
cfg_o  out  N_REGS*32  job registers, packed, reg0 in the LSBs.
start_o  out  1  one-cycle engine start pulse.
clear_o  out  1  one-cycle engine soft-clear pulse.
done_i  in  1  engine end-of-job pulse.
busy_o  out  1  high while in RUNNING.
evt_o  out  N_CORES  one-cycle end-of-job event, driven to all cores.

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE; all job registers 0; job_id 0.
  - Registered outputs go to 0: r_valid, r_data, r_id, start, clear, evt.
  - busy_o is 0 because the state is IDLE.
- Handshake:
  - periph_gnt_o = periph_req_i, combinational, never stalls.
  - An accepted access in cycle t produces r_valid_o=1 in t+1, with r_id_o = id captured at t.
  - Writes also get an r_valid response, with r_data=0.
  - Back-to-back accesses are supported, one per cycle.
- Address map, HWPE block at 0x00:
  - 0x00 COMMIT_AND_TRIGGER: write only.
  - 0x04 ACQUIRE: read only.
  - 0x0C STATUS: read only.
  - 0x14 SOFT_CLEAR: write only.
- Address map, job block at 0x40 + 4*i, i = 0..12, in this order:
  - IN_PTR, OUT_PTR, TOT_LEN.
  - IN_D0_LEN, IN_D0_STRIDE, IN_D1_LEN, IN_D1_STRIDE, IN_D2_STRIDE.
  - OUT_D0_LEN, OUT_D0_STRIDE, OUT_D1_LEN, OUT_D1_STRIDE, OUT_D2_STRIDE.
- Unmapped or wrong-direction accesses: reads return 0; writes are ignored; the response is still given.
- FSM states: IDLE, ACQUIRED, RUNNING.
  - IDLE, ACQUIRE read -> returns {28'b0, job_id}; next state ACQUIRED.
  - ACQUIRED or RUNNING, ACQUIRE read -> returns 0xFFFFFFFF; state unchanged.
  - ACQUIRED, COMMIT write (any data) -> RUNNING at t+1; start_o=1 during t+1 only.
  - COMMIT write in IDLE or RUNNING is ignored.
  - RUNNING, done_i=1 at cycle d -> IDLE at d+1.
    - evt_o = all ones during d+1 only.
    - job_id increments at d+1, 4-bit, wraps from 15 to 0.
  - done_i outside RUNNING is ignored.
- STATUS read returns 1 when the state is RUNNING at the access cycle, else 0. A read in the start_o cycle returns 1.
- Job register writes:
  - Accepted only in ACQUIRED; ignored in IDLE and RUNNING, so cfg_o is stable for the whole job.
  - Byte-granular per be; a write at t is visible on cfg_o at t+1.
  - Job register reads are allowed in any state.
- SOFT_CLEAR write (any data), in any state:
  - At t+1: state IDLE, job registers 0, job_id 0.
  - clear_o=1 during t+1 only; start_o and evt_o are suppressed.
- Simultaneous events in one cycle:
  - SOFT_CLEAR and done_i: the clear wins; no evt_o.
  - done_i and ACQUIRE read: the read sees the pre-edge state (RUNNING) and returns 0xFFFFFFFF.
- Reset mid-job: returns to IDLE next edge; the engine is not notified. The integrator must reset the engine together with this block.

Test Plan:
- Rst, then read 0x04 with id=3 -> r_valid at t+1, r_data=0, r_id=3, busy_o=0. Read 0x04 again -> 0xFFFFFFFF.
- In ACQUIRED: write 0x40=0x100, then 0x48=0x10 with be=4'b0011 over a prior value 0xAAAAAAAA -> cfg_o reg0=0x100, reg2=0xAAAA0010. Read back 0x48 matches.
- Commit at t -> start_o pulses exactly at t+1; STATUS read at t+1 = 1. Write 0x40=0x5 while RUNNING -> reg0 stays 0x100.
- Assert done_i for 1 cycle -> evt_o=1 for 1 cycle; STATUS=0; next ACQUIRE returns 1 (job_id incremented).
- While RUNNING, write 0x14 in the same cycle as done_i -> clear_o pulse, no evt_o, all cfg 0, ACQUIRE returns 0.
- Back-to-back reads of 0x0C, 0x44, 0x99 with ids 1, 2, 3 -> three consecutive r_valid, r_id 1, 2, 3. Unmapped 0x99 returns 0.
